down_timer: RTL and testbench

Four-digit BCD mm:ss countdown timer built from cascaded down-counting digit stages with borrow propagation, driven by an internal clock prescaler. It is the decrementing counterpart of the team's cascaded modulo up-counters. It loads a BCD preset, counts down one second per prescaler period, and flags expiry. It sits between the user-control logic (buttons/registers) and the 7-segment display multiplexer, which consumes Q directly.

---
 rtl/down_timer.sv | 96 +++++++++
 tb/tb_down_timer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: four-digit BCD mm:ss countdown timer with prescaler, pause and expiry/error pulses
module down_timer #(
   parameter int DIV = 100
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        LOAD,
   input  logic [15:0] PRESET,
   input  logic        START,
   input  logic        PAUSE,
   output logic [15:0] Q,
   output logic        RUNNING,
   output logic        ZERO,
   output logic        DONE,
   output logic        ERR
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);
   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
   state_t        r_state, w_state;
   logic [15:0]   r_q, w_q, w_dec;
   logic [PW-1:0] r_pre, w_pre;
   logic          r_done, w_done, r_err, w_err;
   logic          w_valid, w_tick, w_b0, w_b1, w_b2;

   // one-second decrement: each digit stage moves only when every lower stage is 0
   always_comb begin
      w_b0 = r_q[3:0] == 4'd0;
      w_b1 = w_b0 && r_q[7:4] == 4'd0;
      w_b2 = w_b1 && r_q[11:8] == 4'd0;
      w_dec[3:0]   = w_b0 ? 4'd9 : r_q[3:0] - 4'd1;
      w_dec[7:4]   = !w_b0 ? r_q[7:4] : (w_b1 ? 4'd5 : r_q[7:4] - 4'd1);
      w_dec[11:8]  = !w_b1 ? r_q[11:8] : (w_b2 ? 4'd9 : r_q[11:8] - 4'd1);
      w_dec[15:12] = w_b2 ? r_q[15:12] - 4'd1 : r_q[15:12];
   end

   // control: LOAD outside RUN takes the edge, then START, then PAUSE/tick while running
   always_comb begin
      w_state = r_state;
      w_q     = r_q;
      w_pre   = r_pre;
      w_done  = 1'b0;
      w_err   = 1'b0;
      w_valid = PRESET[3:0] <= 4'd9 && PRESET[7:4] <= 4'd5 &&
                PRESET[11:8] <= 4'd9 && PRESET[15:12] <= 4'd9;
      w_tick  = r_pre == LAST;
      if (r_state != RUN && LOAD) begin
         if (w_valid) begin
            w_q     = PRESET;
            w_pre   = '0;
            w_state = IDLE;
         end else begin
            w_err = 1'b1;
         end
      end else if (START && r_q != 16'h0000 && (r_state == IDLE || r_state == PAUSED)) begin
         w_state = RUN;
         w_pre   = (r_state == IDLE) ? '0 : r_pre;
      end else if (r_state == RUN) begin
         if (PAUSE) begin
            w_state = PAUSED;
         end else if (w_tick) begin
            w_q   = w_dec;
            w_pre = '0;
            if (w_dec == 16'h0000) begin
               w_state = EXPIRED;
               w_done  = 1'b1;
            end
         end else begin
            w_pre = r_pre + PW'(1);
         end
      end
   end

   // state, value, prescaler and pulse registers with asynchronous clear
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state <= IDLE;
         r_q     <= 16'h0000;
         r_pre   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_q     <= w_q;
         r_pre   <= w_pre;
         r_done  <= w_done;
         r_err   <= w_err;
      end
   end

   assign Q       = r_q;
   assign RUNNING = r_state == RUN;
   assign ZERO    = r_q == 16'h0000;
   assign DONE    = r_done;
   assign ERR     = r_err;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: two timers (DIV=4 and DIV=1) on shared stimulus, checked against a seconds-count model
module tb_down_timer;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
   logic        clk = 1'b0, clr = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0;
   logic [15:0] preset = 16'h0000;
   logic [15:0] q4, q1;
   logic        run4, zero4, done4, err4, run1, zero1, done1, err1;
   int          total = 0, bad = 0;
   int          dv [2] = '{4, 1};
   int          m_secs [2] = '{0, 0};
   int          m_pre  [2] = '{0, 0};
   int          m_mode [2] = '{M_IDLE, M_IDLE};
   bit          m_done [2] = '{0, 0};
   bit          m_err  [2] = '{0, 0};

   down_timer #(.DIV(4)) u4 (
      .CLK(clk), .CLR(clr), .LOAD(load), .PRESET(preset), .START(start), .PAUSE(pause),
      .Q(q4), .RUNNING(run4), .ZERO(zero4), .DONE(done4), .ERR(err4)
   );
   down_timer #(.DIV(1)) u1 (
      .CLK(clk), .CLR(clr), .LOAD(load), .PRESET(preset), .START(start), .PAUSE(pause),
      .Q(q1), .RUNNING(run1), .ZERO(zero1), .DONE(done1), .ERR(err1)
   );

   always #5 clk = ~clk;

   function automatic bit valid_bcd(logic [15:0] p);
      return p[3:0] <= 4'd9 && p[7:4] <= 4'd5 && p[11:8] <= 4'd9 && p[15:12] <= 4'd9;
   endfunction

   function automatic int bcd2s(logic [15:0] p);
      return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
   endfunction

   function automatic logic [15:0] s2bcd(int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // reference model: time left as a plain seconds count
   always @(posedge clk or posedge clr) begin
      for (int i = 0; i < 2; i++) begin
         if (clr) begin
            m_secs[i] <= 0;
            m_pre[i]  <= 0;
            m_mode[i] <= M_IDLE;
            m_done[i] <= 0;
            m_err[i]  <= 0;
         end else begin
            m_done[i] <= 0;
            m_err[i]  <= 0;
            if (m_mode[i] != M_RUN && load) begin
               if (valid_bcd(preset)) begin
                  m_secs[i] <= bcd2s(preset);
                  m_pre[i]  <= 0;
                  m_mode[i] <= M_IDLE;
               end else m_err[i] <= 1;
            end else if (start && m_secs[i] != 0 && (m_mode[i] == M_IDLE || m_mode[i] == M_PAUSED)) begin
               m_mode[i] <= M_RUN;
               if (m_mode[i] == M_IDLE) m_pre[i] <= 0;
            end else if (m_mode[i] == M_RUN && pause) begin
               m_mode[i] <= M_PAUSED;
            end else if (m_mode[i] == M_RUN && m_pre[i] == dv[i] - 1) begin
               m_secs[i] <= m_secs[i] - 1;
               m_pre[i]  <= 0;
               if (m_secs[i] == 1) begin
                  m_mode[i] <= M_EXP;
                  m_done[i] <= 1;
               end
            end else if (m_mode[i] == M_RUN) begin
               m_pre[i] <= m_pre[i] + 1;
            end
         end
      end
   end

   // every-cycle comparison of both timers against the model
   always @(negedge clk) begin
      chk("q_div4", q4, s2bcd(m_secs[0]));
      chk("running_div4", 16'(run4), 16'(m_mode[0] == M_RUN));
      chk("zero_div4", 16'(zero4), 16'(m_secs[0] == 0));
      chk("done_div4", 16'(done4), 16'(m_done[0]));
      chk("err_div4", 16'(err4), 16'(m_err[0]));
      chk("q_div1", q1, s2bcd(m_secs[1]));
      chk("running_div1", 16'(run1), 16'(m_mode[1] == M_RUN));
      chk("zero_div1", 16'(zero1), 16'(m_secs[1] == 0));
      chk("done_div1", 16'(done1), 16'(m_done[1]));
      chk("err_div1", 16'(err1), 16'(m_err[1]));
   end

   initial begin
      #12 clr = 1'b0;
      chk("reset_q", q4, 16'h0000);
      chk("reset_running", 16'(run4), 16'h0);
      chk("reset_zero", 16'(zero4), 16'h1);
      chk("reset_done", 16'(done4), 16'h0);
      step(1);
      // full countdown of 12 s at DIV=4
      load = 1'b1; preset = 16'h0012;
      step(1);
      load = 1'b0;
      chk("load_0012", q4, 16'h0012);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("start_running", 16'(run4), 16'h1);
      step(12);
      chk("q_after_12", q4, 16'h0009);
      step(35);
      chk("q_after_47", q4, 16'h0001);
      chk("no_early_done", 16'(done4), 16'h0);
      step(1);
      chk("expired_q", q4, 16'h0000);
      chk("done_pulse", 16'(done4), 16'h1);
      chk("expired_not_running", 16'(run4), 16'h0);
      step(1);
      chk("done_one_cycle", 16'(done4), 16'h0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("start_in_expired", 16'(run4), 16'h0);
      // borrow across stages at DIV=1
      load = 1'b1; preset = 16'h1000;
      step(1);
      load = 1'b0; start = 1'b1;
      step(1);
      start = 1'b0;
      chk("div1_no_dec_at_start", q1, 16'h1000);
      step(1);
      chk("div1_0959", q1, 16'h0959);
      step(1);
      chk("div1_0958", q1, 16'h0958);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      chk("pause_beats_tick", q1, 16'h0958);
      load = 1'b1; preset = 16'h0100;
      step(1);
      load = 1'b0;
      chk("div1_load_0100", q1, 16'h0100);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(1);
      chk("div1_0059", q1, 16'h0059);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      // pause and resume at DIV=4: prescaler is kept across the pause
      load = 1'b1; preset = 16'h0005;
      step(1);
      load = 1'b0; start = 1'b1;
      step(1);
      start = 1'b0;
      step(5);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      chk("paused_q", q4, 16'h0004);
      step(20);
      chk("frozen_q", q4, 16'h0004);
      chk("frozen_not_running", 16'(run4), 16'h0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      chk("resume_hold", q4, 16'h0004);
      step(1);
      chk("resume_dec", q4, 16'h0003);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      // invalid presets
      load = 1'b1; preset = 16'h0070;
      step(1);
      load = 1'b0;
      chk("err_0070", 16'(err4), 16'h1);
      chk("err_q_kept", q4, 16'h0003);
      step(1);
      chk("err_one_cycle", 16'(err4), 16'h0);
      load = 1'b1; preset = 16'h0A00;
      step(1);
      load = 1'b0;
      chk("err_0A00", 16'(err4), 16'h1);
      start = 1'b1;
      step(1);
      start = 1'b0; load = 1'b1; preset = 16'h0070;
      step(1);
      load = 1'b0;
      chk("load_in_run_no_err", 16'(err4), 16'h0);
      pause = 1'b1;
      step(1);
      pause = 1'b0; load = 1'b1; start = 1'b1; preset = 16'h0030;
      step(1);
      chk("load_start_q", q4, 16'h0030);
      chk("load_start_idle", 16'(run4), 16'h0);
      step(1);
      load = 1'b0; start = 1'b0;
      chk("load_start_idle_again", 16'(run4), 16'h0);
      // asynchronous clear mid-run
      load = 1'b1; preset = 16'h0007;
      step(1);
      load = 1'b0; start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      chk("pre_clr_q", q4, 16'h0007);
      #2 clr = 1'b1;
      #1;
      chk("clr_q", q4, 16'h0000);
      chk("clr_running", 16'(run4), 16'h0);
      chk("clr_done", 16'(done4), 16'h0);
      #2 clr = 1'b0;
      step(10);
      chk("no_done_after_clr", 16'(done4), 16'h0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("start_with_zero", 16'(run4), 16'h0);
      // randomized traffic, checked each cycle by the model comparator
      for (int c = 0; c < 3000; c++) begin
         load  = $urandom_range(0, 19) == 0;
         start = $urandom_range(0, 7) == 0;
         pause = $urandom_range(0, 24) == 0;
         case ($urandom_range(0, 3))
            0: preset = 16'($urandom);
            1, 2: preset = s2bcd($urandom_range(0, 50));
            default: preset = s2bcd($urandom_range(0, 5999));
         endcase
         if ($urandom_range(0, 499) == 0) begin
            #1 clr = 1'b1;
            #2 clr = 1'b0;
         end
         step(1);
      end
      load = 1'b0; start = 1'b0; pause = 1'b0;
      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
